// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped machine timer: register map, CTRL layout, window base.
package mmio_pkg;

    typedef enum logic [2:0] {
        RegMtimeLo = 3'd0,
        RegMtimeHi = 3'd1,
        RegCmpLo   = 3'd2,
        RegCmpHi   = 3'd3,
        RegCtrl    = 3'd4
    } reg_addr_e;

    localparam int unsigned CtrlRunBit = 0;
    localparam int unsigned CtrlDivLsb = 8;
    localparam int unsigned CtrlDivW   = 8;

    localparam logic [31:0] TimerBase = 32'h0200_4000;

    // Byte-lane merge: lanes with be set take new_val, the rest keep old_val.
    function automatic logic [31:0] apply_be(logic [31:0] old_val, logic [31:0] new_val,
                                             logic [3:0] be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for mtime: one tick every div_i+1 cycles while run_i is high; clr_i restarts count.
module timer_prescaler #(
    parameter int unsigned PrescW = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PrescW-1:0] div_i,
    input  logic              run_i,
    input  logic              clr_i,
    output logic              tick_o
);

    logic [PrescW-1:0] presc_q, presc_d;

    assign tick_o = run_i && (presc_q == div_i);

    always_comb begin
        presc_d = presc_q;
        if (clr_i || tick_o) begin
            presc_d = '0;
        end else if (run_i) begin
            presc_d = presc_q + PrescW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt and 1-cycle read latency.
// Define TIMER_SNAPSHOT_EN to make MTIME_HI reads return the high word latched by the last LO read.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int unsigned PrescW = 8,
    parameter int unsigned RstDiv = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        timer_int_o
);

    logic [63:0]       mtime_q, mtime_d, mtime_inc;
    logic [63:0]       cmp_q, cmp_d;
    logic              run_q, run_d;
    logic [PrescW-1:0] div_q, div_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              timer_int_q, timer_int_d;
    logic [31:0]       ctrl_rd;
    logic              tick, wr, rd, ctrl_wr;
    reg_addr_e         addr;
`ifdef TIMER_SNAPSHOT_EN
    logic [31:0]       hi_snap_q, hi_snap_d;
`endif

    assign addr = reg_addr_e'(addr_i);
    assign wr   = en_i && (we_i != 4'b0000);
    assign rd   = en_i && (we_i == 4'b0000);

    timer_prescaler #(
        .PrescW (PrescW)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .div_i  (div_q),
        .run_i  (run_q),
        .clr_i  (ctrl_wr),
        .tick_o (tick)
    );

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CtrlRunBit] = run_q;
        ctrl_rd[CtrlDivLsb +: CtrlDivW] = CtrlDivW'(div_q);
    end

    always_comb begin
        mtime_inc = mtime_q + 64'(tick);
        mtime_d   = mtime_inc;
        cmp_d     = cmp_q;
        run_d     = run_q;
        div_d     = div_q;
        ctrl_wr   = 1'b0;
        rdata_d   = rdata_q;
`ifdef TIMER_SNAPSHOT_EN
        hi_snap_d = hi_snap_q;
`endif
        // Written lanes override the incremented value; unwritten lanes keep the tick.
        if (wr) begin
            case (addr)
                RegMtimeLo: mtime_d[31:0]  = apply_be(mtime_inc[31:0], wdata_i, we_i);
                RegMtimeHi: begin
                    mtime_d[63:32] = apply_be(mtime_inc[63:32], wdata_i, we_i);
`ifdef TIMER_SNAPSHOT_EN
                    hi_snap_d = mtime_d[63:32];
`endif
                end
                RegCmpLo:   cmp_d[31:0]    = apply_be(cmp_q[31:0], wdata_i, we_i);
                RegCmpHi:   cmp_d[63:32]   = apply_be(cmp_q[63:32], wdata_i, we_i);
                RegCtrl: begin
                    ctrl_wr = 1'b1;
                    if (we_i[CtrlRunBit / 8]) run_d = wdata_i[CtrlRunBit];
                    if (we_i[CtrlDivLsb / 8]) div_d = PrescW'(wdata_i[CtrlDivLsb +: CtrlDivW]);
                end
                default: ;
            endcase
        end
        // Reads return pre-edge state, so the same-cycle tick is not visible.
        if (rd) begin
            case (addr)
                RegMtimeLo: begin
                    rdata_d = mtime_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
                    hi_snap_d = mtime_q[63:32];
`endif
                end
`ifdef TIMER_SNAPSHOT_EN
                RegMtimeHi: rdata_d = hi_snap_q;
`else
                RegMtimeHi: rdata_d = mtime_q[63:32];
`endif
                RegCmpLo:   rdata_d = cmp_q[31:0];
                RegCmpHi:   rdata_d = cmp_q[63:32];
                RegCtrl:    rdata_d = ctrl_rd;
                default:    rdata_d = '0;
            endcase
        end
        timer_int_d = (mtime_d >= cmp_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q     <= '0;
            cmp_q       <= '1;
            run_q       <= 1'b0;
            div_q       <= PrescW'(RstDiv);
            rdata_q     <= '0;
            timer_int_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            cmp_q       <= cmp_d;
            run_q       <= run_d;
            div_q       <= div_d;
            rdata_q     <= rdata_d;
            timer_int_q <= timer_int_d;
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_snap_q <= '0;
        end else begin
            hi_snap_q <= hi_snap_d;
        end
    end
`endif

    assign rdata_o     = rdata_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus random bus traffic against a model.
module tb_mmio_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [2:0]  addr = 3'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        timer_int;
    logic        chk_on = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mmio_timer #(
        .PrescW (8),
        .RstDiv (0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .timer_int_o (timer_int)
    );

    // Architectural view of the timer: cycles elapsed in the current tick period, not a counter RTL.
    typedef struct {
        logic [63:0] mtime;
        logic [63:0] cmp;
        logic [31:0] hi_snap;
        logic        run;
        logic [7:0]  div;
        int          elapsed;
        logic [31:0] rdata;
        logic        irq;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t reset_state();
        mstate_t s;
        s.mtime = 64'd0;
        s.cmp = {64{1'b1}};
        s.hi_snap = 32'd0;
        s.run = 1'b0;
        s.div = 8'd0;
        s.elapsed = 0;
        s.rdata = 32'd0;
        s.irq = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_value(mstate_t s, logic [2:0] a);
        case (a)
            3'd0: return s.mtime[31:0];
`ifdef TIMER_SNAPSHOT_EN
            3'd1: return s.hi_snap;
`else
            3'd1: return s.mtime[63:32];
`endif
            3'd2: return s.cmp[31:0];
            3'd3: return s.cmp[63:32];
            3'd4: return {16'h0, s.div, 7'h0, s.run};
            default: return 32'h0;
        endcase
    endfunction

    function automatic mstate_t step(mstate_t s, logic e, logic [3:0] w, logic [2:0] a,
                                     logic [31:0] d);
        mstate_t n;
        logic    tk;
        n = s;
        tk = s.run && (s.elapsed == int'(s.div));
        if (s.run) n.elapsed = tk ? 0 : s.elapsed + 1;
        n.mtime = s.mtime + (tk ? 64'd1 : 64'd0);
        if (e && w != 4'h0) begin
            case (a)
                3'd0: n.mtime[31:0] = merge(n.mtime[31:0], d, w);
                3'd1: begin
                    n.mtime[63:32] = merge(n.mtime[63:32], d, w);
                    n.hi_snap = n.mtime[63:32];
                end
                3'd2: n.cmp[31:0] = merge(s.cmp[31:0], d, w);
                3'd3: n.cmp[63:32] = merge(s.cmp[63:32], d, w);
                3'd4: begin
                    n.elapsed = 0;
                    if (w[0]) n.run = d[0];
                    if (w[1]) n.div = d[15:8];
                end
                default: ;
            endcase
        end
        if (e && w == 4'h0) begin
            n.rdata = reg_value(s, a);
            if (a == 3'd0) n.hi_snap = s.mtime[63:32];
        end
        n.irq = (n.mtime >= n.cmp);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_state();
        else        m <= step(m, en, we, addr, wdata);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("rdata_vs_model", 64'(rdata), 64'(m.rdata));
            check("irq_vs_model", 64'(timer_int), 64'(m.irq));
        end
    end

    // Tasks are entered on a falling edge and return on the next falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        en = 1'b1; we = be; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 4'h0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        en = 1'b1; we = 4'h0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] v;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Reset in the middle of activity
        wr(3'd2, 32'h0, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd4, 32'h0000_0301, 4'hF);
        rd(3'd4, v);
        check("ctrl_readback", 64'(v), 64'h0000_0301);
        check("irq_before_reset", 64'(timer_int), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_irq", 64'(timer_int), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(3'd2, v); check("rst_cmp_lo", 64'(v), 64'hFFFF_FFFF);
        rd(3'd3, v); check("rst_cmp_hi", 64'(v), 64'hFFFF_FFFF);
        rd(3'd4, v); check("rst_ctrl", 64'(v), 64'h0);
        rd(3'd0, v); check("rst_mtime_lo", 64'(v), 64'h0);

        // Count with DIV=3: one tick per 4 clocks
        wr(3'd4, 32'h0000_0301, 4'hF);
        repeat (40) @(negedge clk);
        rd(3'd0, v); check("count_40clk", 64'(v), 64'd10);
        check("model_count", m.mtime, 64'd10);
        wr(3'd4, 32'h0, 4'hF);

        // 64-bit carry from LO into HI
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h0000_0001, 4'hF);
        wr(3'd4, 32'h0, 4'hF);
        rd(3'd0, v); check("wrap_lo", 64'(v), 64'd0);
        rd(3'd1, v); check("wrap_hi", 64'(v), 64'd1);

        // Compare interrupt rise and fall
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd2, 32'd20, 4'hF);
        check("irq_idle", 64'(timer_int), 64'd0);
        wr(3'd4, 32'h0000_0001, 4'hF);
        repeat (19) @(negedge clk);
        check("irq_at_19", 64'(timer_int), 64'd0);
        @(negedge clk);
        check("irq_at_20", 64'(timer_int), 64'd1);
        check("model_mtime_20", m.mtime, 64'd20);
        wr(3'd3, 32'h1, 4'hF);
        check("irq_after_cmp_hi", 64'(timer_int), 64'd0);
        wr(3'd4, 32'h0, 4'hF);

        // Byte write colliding with a tick; stopping write also ticks once
        wr(3'd0, 32'h1122_3344, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h0000_0001, 4'hF);
        wr(3'd0, 32'h0000_AB00, 4'b0010);
        wr(3'd4, 32'h0, 4'hF);
        rd(3'd0, v); check("byte_collision_lo", 64'(v), 64'h1122_AB46);
        rd(3'd1, v); check("byte_collision_hi", 64'(v), 64'h0);

        // LO-then-HI read across a carry
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h0000_0001, 4'hF);
        rd(3'd0, v); check("snap_lo", 64'(v), 64'hFFFF_FFFE);
        repeat (5) @(negedge clk);
        rd(3'd1, v);
`ifdef TIMER_SNAPSHOT_EN
        check("snap_hi", 64'(v), 64'd0);
`else
        check("live_hi", 64'(v), 64'd1);
`endif
        wr(3'd4, 32'h0, 4'hF);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            addr  = 3'($urandom);
            wdata = $urandom;
            if (addr == 3'd4) wdata[15:8] = 8'($urandom_range(0, 3));
            if (addr == 3'd1 || addr == 3'd3) wdata = 32'($urandom_range(0, 1));
            if (addr == 3'd2 && $urandom_range(0, 1) != 0) wdata = 32'($urandom_range(0, 300));
            @(negedge clk);
        end
        en = 1'b0; we = 4'h0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
